// File: rtl/rsa_operand_store.sv
// Word-serial loader for the RSA operands n, d and c. Each operand is assembled
// from BUS_W-bit beats and the full set is offered to the mod-exp core by handshake.
//
// Handshakes: a write beat transfers on a cycle where wr_valid && wr_ready; the
// operand set transfers to the core on a cycle where key_valid && key_ready.
// Neither valid depends combinationally on its ready.
module rsa_operand_store #(
    parameter int WIDTH = 32,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_sel,
    input  logic [BUS_W-1:0] wr_data,
    output logic             key_valid,
    input  logic             key_ready,
    input  logic             done,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] primeNumOut,
    output logic [WIDTH-1:0] privateKeyOut,
    output logic [WIDTH-1:0] cipherOut,
    output logic [1:0]       dbg_state_o
);

    localparam int WORDS = WIDTH / BUS_W;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             err_q, err_d;

    logic             beat_acc;
    logic             same_sel;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] stage_w;

    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        stage_d   = stage_q;
        n_d       = n_q;
        d_d       = d_q;
        c_d       = c_q;
        err_d     = 1'b0;

        beat_acc = wr_valid && (state_q == S_IDLE);
        same_sel = (wr_sel == cur_sel_q);
        idx      = same_sel ? cnt_q : '0;

        // A change of target operand throws away whatever was half-assembled.
        stage_w = same_sel ? stage_q : '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx == CW'(i)) begin
                stage_w[i*BUS_W +: BUS_W] = wr_data;
            end
        end

        if (beat_acc) begin
            if (wr_sel == 2'd3) begin
                err_d     = 1'b1;
                cnt_d     = '0;
                cur_sel_d = 2'd3;
                stage_d   = '0;
            end else begin
                cur_sel_d = wr_sel;
                if (idx == CW'(WORDS - 1)) begin
                    cnt_d   = '0;
                    stage_d = '0;
                    case (wr_sel)
                        2'd0:    begin n_d = stage_w; vld_d[0] = 1'b1; end
                        2'd1:    begin d_d = stage_w; vld_d[1] = 1'b1; end
                        default: begin c_d = stage_w; vld_d[2] = 1'b1; end
                    endcase
                end else begin
                    cnt_d   = idx + CW'(1);
                    stage_d = stage_w;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (vld_q == 3'b111) state_d = S_OFFER;
            end
            S_OFFER: begin
                if (key_ready) state_d = S_BUSY;
            end
            S_BUSY: begin
                // The ciphertext is consumed; the key stays loaded for the next block.
                if (done) begin
                    state_d  = S_IDLE;
                    vld_d[2] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= S_IDLE;
            vld_q     <= '0;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            stage_q   <= '0;
            n_q       <= '0;
            d_q       <= '0;
            c_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            stage_q   <= stage_d;
            n_q       <= n_d;
            d_q       <= d_d;
            c_q       <= c_d;
            err_q     <= err_d;
        end
    end

    assign wr_ready      = (state_q == S_IDLE);
    assign key_valid     = (state_q == S_OFFER);
    assign busy          = (state_q == S_BUSY);
    assign err           = err_q;
    assign primeNumOut   = n_q;
    assign privateKeyOut = d_q;
    assign cipherOut     = c_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rsa_operand_store.sv
// Bench for rsa_operand_store: directed scenarios followed by random traffic, all
// outputs compared every cycle against a queue-based behavioural model.
module tb_rsa_operand_store;

    localparam int WIDTH = 32;
    localparam int BUS_W = 8;
    localparam int WORDS = WIDTH / BUS_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [1:0]       wr_sel = 2'd0;
    logic [BUS_W-1:0] wr_data = '0;
    logic             key_valid;
    logic             key_ready = 1'b0;
    logic             done = 1'b0;
    logic             busy;
    logic             err;
    logic [WIDTH-1:0] primeNumOut;
    logic [WIDTH-1:0] privateKeyOut;
    logic [WIDTH-1:0] cipherOut;
    logic [1:0]       dbg_state;

    int tests = 0;
    int fails = 0;

    // model: phase 0=IDLE 1=OFFER 2=BUSY
    int               m_phase;
    logic [2:0]       m_vld;
    logic [WIDTH-1:0] m_op[3];
    logic             m_err;
    int               m_cur;
    logic [BUS_W-1:0] m_words[$];

    rsa_operand_store #(.WIDTH(WIDTH), .BUS_W(BUS_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
        .key_valid(key_valid), .key_ready(key_ready), .done(done),
        .busy(busy), .err(err),
        .primeNumOut(primeNumOut), .privateKeyOut(privateKeyOut), .cipherOut(cipherOut),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_vld   = 3'b000;
        m_op[0] = '0;
        m_op[1] = '0;
        m_op[2] = '0;
        m_err   = 1'b0;
        m_cur   = 0;
        m_words.delete();
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [BUS_W-1:0] dat,
                         input logic kr, input logic dn, input logic clr, input logic rs);
        int               nphase;
        logic [WIDTH-1:0] val;
        wr_valid  = v;
        wr_sel    = s;
        wr_data   = dat;
        key_ready = kr;
        done      = dn;
        clear     = clr;
        rst       = rs;
        if (rs || clr) begin
            model_reset();
        end else begin
            nphase = m_phase;
            if (m_phase == 0 && m_vld == 3'b111) nphase = 1;
            if (m_phase == 1 && kr) nphase = 2;
            if (m_phase == 2 && dn) begin
                nphase   = 0;
                m_vld[2] = 1'b0;
            end
            m_err = 1'b0;
            if (v && m_phase == 0) begin
                if (s == 2'd3) begin
                    m_err = 1'b1;
                    m_words.delete();
                    m_cur = 3;
                end else begin
                    if (int'(s) != m_cur) m_words.delete();
                    m_cur = int'(s);
                    m_words.push_back(dat);
                    if (m_words.size() == WORDS) begin
                        val = '0;
                        for (int i = 0; i < WORDS; i++) val = val | (WIDTH'(m_words[i]) << (BUS_W * i));
                        m_op[s]  = val;
                        m_vld[s] = 1'b1;
                        m_words.delete();
                    end
                end
            end
            m_phase = nphase;
        end
        @(posedge clk);
        #1;
        check("wr_ready",  WIDTH'(wr_ready),  WIDTH'(m_phase == 0));
        check("key_valid", WIDTH'(key_valid), WIDTH'(m_phase == 1));
        check("busy",      WIDTH'(busy),      WIDTH'(m_phase == 2));
        check("err",       WIDTH'(err),       WIDTH'(m_err));
        check("n_out",     primeNumOut,       m_op[0]);
        check("d_out",     privateKeyOut,     m_op[1]);
        check("c_out",     cipherOut,         m_op[2]);
    endtask

    task automatic beat(input logic [1:0] s, input logic [BUS_W-1:0] dat);
        cycle(1'b1, s, dat, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic kr, input logic dn);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, kr, dn, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [1:0] s, input logic [WIDTH-1:0] val);
        for (int i = 0; i < WORDS; i++) beat(s, val[i*BUS_W +: BUS_W]);
    endtask

    initial begin
        model_reset();
        // reset for two cycles
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_n", primeNumOut, 32'h0);
        check("rst_wr_ready", WIDTH'(wr_ready), 32'h1);

        // full set, LS word first
        load(2'd0, 32'h12345678);
        load(2'd1, 32'hDEADBEEF);
        load(2'd2, 32'h01020304);
        check("set_n", primeNumOut, 32'h12345678);
        check("set_d", privateKeyOut, 32'hDEADBEEF);
        check("set_c", cipherOut, 32'h01020304);
        check("set_kv_early", WIDTH'(key_valid), 32'h0);
        idle(1, 1'b0, 1'b0);
        check("set_kv", WIDTH'(key_valid), 32'h1);

        // stalled offer, accept, compute, then reload only c
        idle(5, 1'b0, 1'b0);
        check("stall_kv", WIDTH'(key_valid), 32'h1);
        check("stall_wr_ready", WIDTH'(wr_ready), 32'h0);
        beat(2'd0, 8'h99);
        check("stall_n_kept", primeNumOut, 32'h12345678);
        idle(1, 1'b1, 1'b0);
        check("accept_busy", WIDTH'(busy), 32'h1);
        idle(2, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b1);
        check("done_idle", WIDTH'(wr_ready), 32'h1);
        idle(2, 1'b0, 1'b0);
        check("c_consumed_kv", WIDTH'(key_valid), 32'h0);
        load(2'd2, 32'h11223344);
        idle(1, 1'b0, 1'b0);
        check("reload_kv", WIDTH'(key_valid), 32'h1);
        check("reload_n", primeNumOut, 32'h12345678);
        check("reload_c", cipherOut, 32'h11223344);
        idle(1, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b1);

        // illegal select
        beat(2'd3, 8'hFF);
        check("illegal_err", WIDTH'(err), 32'h1);
        idle(1, 1'b0, 1'b0);
        check("illegal_err_drop", WIDTH'(err), 32'h0);
        check("illegal_d", privateKeyOut, 32'hDEADBEEF);

        // partial n then d: n untouched
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        beat(2'd0, 8'hAA);
        beat(2'd0, 8'hBB);
        load(2'd1, 32'h0BADF00D);
        idle(2, 1'b0, 1'b0);
        check("partial_n", primeNumOut, 32'h0);
        check("partial_d", privateKeyOut, 32'h0BADF00D);
        check("partial_kv", WIDTH'(key_valid), 32'h0);

        // clear wins over done while busy
        load(2'd0, 32'hCAFEF00D);
        load(2'd2, 32'h00C0FFEE);
        idle(1, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        check("clr_pre_busy", WIDTH'(busy), 32'h1);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_n", primeNumOut, 32'h0);
        check("clr_idle", WIDTH'(wr_ready), 32'h1);
        idle(2, 1'b0, 1'b0);
        check("clr_kv", WIDTH'(key_valid), 32'h0);

        // reset mid-load restarts at word 0
        beat(2'd0, 8'h55);
        beat(2'd0, 8'h66);
        cycle(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        load(2'd0, 32'hA1B2C3D4);
        check("rst_mid_n", primeNumOut, 32'hA1B2C3D4);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            logic             v, kr, dn, clr, rs;
            logic [1:0]       s;
            logic [BUS_W-1:0] dat;
            v   = ($urandom_range(0, 9) < 7);
            s   = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            dat = BUS_W'($urandom);
            kr  = ($urandom_range(0, 2) == 0);
            dn  = ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 99) == 0);
            rs  = ($urandom_range(0, 199) == 0);
            cycle(v, s, dat, kr, dn, clr, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
